// File: rtl/icode_parser.sv
// rtl/icode_parser.sv - Y86 byte stream to per-instruction icode parser (option: ICODE_PARSER_FN_CHECK_EN)
module icode_parser #(
    parameter int ICODESIZE = 4,
    parameter int CNTBITS   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic [ICODESIZE-1:0] icode_out,
    output logic                 icode_valid,
    input  logic                 icode_ready,
    output logic                 error,
    output logic [CNTBITS-1:0]   instr_count
);

    localparam logic [1:0] S_HEAD = 2'd0;
    localparam logic [1:0] S_BODY = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    logic [1:0]           r_state;
    logic [3:0]           r_remaining;
    logic [ICODESIZE-1:0] r_icode_out;
    logic                 r_icode_valid;
    logic [CNTBITS-1:0]   r_count;

    logic [3:0] w_nibble;
    logic [3:0] w_ifun;
    logic [3:0] w_len;
    logic       w_fn_ok;
    logic       w_head_ok;
    logic       w_byte_ready;
    logic       w_take;

    assign w_nibble = byte_in[7:4];
    assign w_ifun   = byte_in[3:0];

    // Instruction length in bytes; zero marks an invalid icode.
    always_comb begin
        w_len = 4'd0;
        case (w_nibble)
            4'h0, 4'h1, 4'h9:        w_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB:  w_len = 4'd2;
            4'h3, 4'h4, 4'h5:        w_len = 4'd10;
            4'h7, 4'h8:              w_len = 4'd9;
            default:                 w_len = 4'd0;
        endcase
    end

`ifdef ICODE_PARSER_FN_CHECK_EN
    always_comb begin
        w_fn_ok = 1'b0;
        case (w_nibble)
            4'h2, 4'h7: w_fn_ok = (w_ifun <= 4'd6);
            4'h6:       w_fn_ok = (w_ifun <= 4'd3);
            default:    w_fn_ok = (w_ifun == 4'd0);
        endcase
    end
`else
    logic w_unused_ifun;
    assign w_unused_ifun = ^w_ifun;
    assign w_fn_ok       = 1'b1;
`endif

    assign w_head_ok = (w_len != 4'd0) && w_fn_ok;

    // Only HEAD can be back-pressured; the icode_ready term is combinational there.
    always_comb begin
        w_byte_ready = 1'b0;
        case (r_state)
            S_HEAD:  w_byte_ready = !(r_icode_valid && !icode_ready);
            S_BODY:  w_byte_ready = 1'b1;
            default: w_byte_ready = 1'b0;
        endcase
    end

    assign w_take = byte_valid && w_byte_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_HEAD;
            r_remaining   <= 4'd0;
            r_icode_out   <= '0;
            r_icode_valid <= 1'b0;
            r_count       <= '0;
        end else begin
            if (r_icode_valid && icode_ready) begin
                r_icode_valid <= 1'b0;
            end
            case (r_state)
                S_HEAD: begin
                    if (w_take) begin
                        if (w_head_ok) begin
                            // A new head overrides the drain above in the same cycle.
                            r_icode_out   <= byte_in[7 -: ICODESIZE];
                            r_icode_valid <= 1'b1;
                            r_count       <= r_count + CNTBITS'(1);
                            if (w_len != 4'd1) begin
                                r_remaining <= w_len - 4'd1;
                                r_state     <= S_BODY;
                            end
                        end else begin
                            r_state <= S_ERR;
                        end
                    end
                end
                S_BODY: begin
                    if (w_take) begin
                        r_remaining <= r_remaining - 4'd1;
                        if (r_remaining == 4'd1) begin
                            r_state <= S_HEAD;
                        end
                    end
                end
                default: r_state <= S_ERR;
            endcase
        end
    end

    assign byte_ready  = w_byte_ready;
    assign icode_out   = r_icode_out;
    assign icode_valid = r_icode_valid;
    assign error       = (r_state == S_ERR);
    assign instr_count = r_count;

endmodule

// File: tb/tb_icode_parser.sv
// tb/tb_icode_parser.sv - randomized and directed bench for icode_parser against a behavioural model
module tb_icode_parser;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [3:0]  icode_out;
    logic        icode_valid;
    logic        icode_ready;
    logic        error;
    logic [15:0] instr_count;

    icode_parser #(.ICODESIZE(4), .CNTBITS(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .icode_out   (icode_out),
        .icode_valid (icode_valid),
        .icode_ready (icode_ready),
        .error       (error),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;

    // Model: bytes still owed to the current instruction, pending icode, sticky error.
    bit          m_valid;
    logic [3:0]  m_icode;
    logic [15:0] m_count;
    bit          m_err;
    int          m_left;

    function automatic int len_of(input logic [7:0] b);
        int hi = int'(b[7:4]);
        int lo = int'(b[3:0]);
        int l;
        if (hi == 0 || hi == 1 || hi == 9) l = 1;
        else if (hi == 2 || hi == 6 || hi == 10 || hi == 11) l = 2;
        else if (hi >= 3 && hi <= 5) l = 10;
        else if (hi == 7 || hi == 8) l = 9;
        else l = 0;
`ifdef ICODE_PARSER_FN_CHECK_EN
        if (hi == 2 || hi == 7) begin
            if (lo > 6) l = 0;
        end else if (hi == 6) begin
            if (lo > 3) l = 0;
        end else if (lo != 0) l = 0;
`else
        lo = lo;
`endif
        return l;
    endfunction

    function automatic bit m_ready();
        if (m_err) return 1'b0;
        if (m_left > 0) return 1'b1;
        return !(m_valid && !icode_ready);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_icode = 0; m_count = 0; m_err = 0; m_left = 0;
    endtask

    // One clock: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic step();
        bit acc, drn;
        int l;
        @(negedge clock);
        chk("byte_ready", 32'(byte_ready), 32'(m_ready()));
        chk("icode_valid", 32'(icode_valid), 32'(m_valid));
        chk("error", 32'(error), 32'(m_err));
        chk("instr_count", 32'(instr_count), 32'(m_count));
        if (m_valid) chk("icode_out", 32'(icode_out), 32'(m_icode));
        acc = byte_valid && m_ready();
        drn = m_valid && icode_ready;
        if (drn) m_valid = 0;
        if (acc) begin
            if (m_left > 0) m_left--;
            else begin
                l = len_of(byte_in);
                if (l == 0) m_err = 1;
                else begin
                    m_valid = 1;
                    m_icode = byte_in[7:4];
                    m_count = m_count + 16'd1;
                    m_left  = l - 1;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        chk("rst_icode_valid", 32'(icode_valid), 32'd0);
        chk("rst_icode_out", 32'(icode_out), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        byte_in = b;
        byte_valid = 1'b1;
        step();
    endtask

    initial begin
        reset = 1'b1; byte_in = 0; byte_valid = 0; icode_ready = 1;
        model_reset();
        @(posedge clock); #1;
        do_reset();

        // Back-to-back 1-byte instructions.
        icode_ready = 1;
        send(8'h10); chk("t1_ic0", 32'(icode_out), 32'd1);
        send(8'h00); chk("t1_ic1", 32'(icode_out), 32'd0);
        send(8'h90); chk("t1_ic2", 32'(icode_out), 32'd9);
        chk("t1_count", 32'(instr_count), 32'd3);
        chk("t1_ready", 32'(byte_ready), 32'd1);

        // 10-byte instruction then a 2-byte one.
        do_reset();
        send(8'h30); chk("t2_ic3", 32'(icode_out), 32'd3);
        for (int i = 0; i < 9; i++) send(8'hC5);
        chk("t2_body_count", 32'(instr_count), 32'd1);
        chk("t2_body_valid", 32'(icode_valid), 32'd0);
        send(8'h20); chk("t2_ic2", 32'(icode_out), 32'd2);
        send(8'h01);
        chk("t2_count2", 32'(instr_count), 32'd2);
        send(8'h10); chk("t2_next_head", 32'(instr_count), 32'd3);

        // Back-pressure and same-cycle replace.
        do_reset();
        icode_ready = 0;
        send(8'h10);
        chk("t3_held_ready", 32'(byte_ready), 32'd0);
        send(8'h10);
        icode_ready = 1; #1;
        chk("t3_comb_ready", 32'(byte_ready), 32'd1);
        send(8'h10);
        chk("t3_valid", 32'(icode_valid), 32'd1);
        chk("t3_icode", 32'(icode_out), 32'd1);
        chk("t3_count", 32'(instr_count), 32'd2);

        // Invalid head.
        do_reset();
        send(8'hC0);
        chk("t4_error", 32'(error), 32'd1);
        chk("t4_ready", 32'(byte_ready), 32'd0);
        chk("t4_count", 32'(instr_count), 32'd0);
        send(8'h10); send(8'h10);
        do_reset();
        chk("t4_err_clr", 32'(error), 32'd0);
        send(8'h10); chk("t4_after", 32'(icode_out), 32'd1);

        // Reset mid-instruction.
        do_reset();
        send(8'h70); send(8'h11); send(8'h22); send(8'h33);
        do_reset();
        send(8'h00);
        chk("t5_ic0", 32'(icode_out), 32'd0);
        chk("t5_valid", 32'(icode_valid), 32'd1);
        send(8'h10);
        chk("t5_head", 32'(instr_count), 32'd2);

        // ifun handling.
        do_reset();
        send(8'h65);
`ifdef ICODE_PARSER_FN_CHECK_EN
        chk("t6_fn_err", 32'(error), 32'd1);
`else
        chk("t6_ic6", 32'(icode_out), 32'd6);
        send(8'h10);
        chk("t6_body", 32'(instr_count), 32'd1);
        send(8'h10);
        chk("t6_head", 32'(instr_count), 32'd2);
`endif

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            logic [7:0] b;
            if (m_err && $urandom_range(0, 7) == 0) do_reset();
            byte_valid  = ($urandom_range(0, 3) != 0);
            icode_ready = ($urandom_range(0, 9) < 7);
            b = 8'($urandom_range(0, 255));
            if (m_left == 0 && $urandom_range(0, 99) != 0) begin
                while (len_of(b) == 0) begin
                    b = 8'($urandom_range(0, 255));
                    if ($urandom_range(0, 1) == 0) b[3:0] = 4'h0;
                end
            end
            byte_in = b;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
